// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IF fetches and MEM loads/stores
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_LAT = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_re,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              stall_if,
  output logic              stall_mem
);
  localparam int CW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic          own_mem, lat_we, mem_any, grant, grant_if, starved;
  logic [CW-1:0] lat_cnt;
  logic [SW-1:0] starve_cnt;
  assign mem_any   = mem_re | mem_we;
  assign starved   = starve_cnt == SW'(STARVE_MAX);
  assign grant     = state == IDLE && (mem_any || if_req);
  assign grant_if  = if_req & (~mem_any | starved);
  assign if_ready  = state == DONE && !own_mem;
  assign mem_ready = state == DONE && own_mem;
  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = mem_any & ~mem_ready;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = grant ? ISSUE : IDLE;
      ISSUE:   state_nx = lat_we ? DONE : WAIT;
      WAIT:    state_nx = lat_cnt == '0 ? DONE : WAIT;
      default: state_nx = IDLE;
    endcase
  end
  // ram_addr/ram_wdata double as the latched request; they hold until the next grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      own_mem    <= 1'b0;
      lat_we     <= 1'b0;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
    end else begin
      state  <= state_nx;
      ram_en <= grant;
      ram_we <= grant && !grant_if && mem_we;
      if (grant) begin
        own_mem   <= ~grant_if;
        lat_we    <= ~grant_if & mem_we;
        ram_addr  <= grant_if ? if_addr : mem_addr;
        ram_wdata <= mem_wdata;
      end
      if (state == IDLE)
        starve_cnt <= (grant_if || !if_req) ? '0 : (mem_any && !starved) ? starve_cnt + SW'(1) : starve_cnt;
      if (state == ISSUE) lat_cnt <= CW'(MEM_LAT - 1);
      else if (state == WAIT && lat_cnt != '0) lat_cnt <= lat_cnt - CW'(1);
      if (state == WAIT && lat_cnt == '0) begin
        if (own_mem) mem_rdata <= ram_rdata;
        else if_rdata <= ram_rdata;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, latency, starvation and reset
module tb_mem_port_arbiter;
  logic        clk = 1'b0, rst = 1'b0;
  logic        if_req = 1'b0, mem_re = 1'b0, mem_we = 1'b0;
  logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata, ram_rdata;
  logic        if_ready, mem_ready, ram_en, ram_we, stall_if, stall_mem;
  logic        l1_re = 1'b0;
  logic [31:0] l1_addr = '0;
  logic [31:0] l1_if_rdata, l1_mem_rdata, l1_ram_addr, l1_ram_wdata, l1_ram_rdata;
  logic        l1_if_ready, l1_mem_ready, l1_ram_en, l1_ram_we, l1_stall_if, l1_stall_mem;
  logic [31:0] pipe [2];
  int          n_chk = 0, n_pass = 0;
  logic [31:0] exp_mrd;
  always #5 clk = ~clk;

  mem_port_arbiter u_dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  mem_port_arbiter #(.MEM_LAT(1)) u_l1 (
    .clk(clk), .rst(rst), .if_req(1'b0), .if_addr(32'h0), .if_rdata(l1_if_rdata), .if_ready(l1_if_ready),
    .mem_re(l1_re), .mem_we(1'b0), .mem_addr(l1_addr), .mem_wdata(32'h0), .mem_rdata(l1_mem_rdata),
    .mem_ready(l1_mem_ready), .ram_en(l1_ram_en), .ram_we(l1_ram_we), .ram_addr(l1_ram_addr),
    .ram_wdata(l1_ram_wdata), .ram_rdata(l1_ram_rdata), .stall_if(l1_stall_if), .stall_mem(l1_stall_mem)
  );

  function automatic logic [31:0] data_for(input logic [31:0] a);
    return a == 32'h40 ? 32'hDEADBEEF : {a[15:0], 16'hC0DE};
  endfunction

  // memory models: read data is valid only MEM_LAT cycles after the ram_en cycle
  always @(posedge clk) begin
    pipe[0]      <= (ram_en && !ram_we) ? data_for(ram_addr) : 32'hBAD0BAD0;
    pipe[1]      <= pipe[0];
    l1_ram_rdata <= (l1_ram_en && !l1_ram_we) ? data_for(l1_ram_addr) : 32'hBAD0BAD0;
  end
  assign ram_rdata = pipe[1];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] seq;
    int         n, both;
    #1;
    chk("rst_ram_en", ram_en, 0);
    chk("rst_rdata", {if_rdata, mem_rdata}, 0);
    chk("rst_ready", {if_ready, mem_ready}, 0);
    step(2);
    rst = 1'b1;
    step();
    // single fetch
    if_req = 1'b1; if_addr = 32'h40;
    #1 chk("f_stall_t", stall_if, 1);
    chk("f_en_t", ram_en, 0);
    step();
    chk("f_en_t1", {ram_en, ram_we, ram_addr}, {2'b10, 32'h40});
    step();
    chk("f_en_t2", ram_en, 0);
    step();
    chk("f_t3", {stall_if, if_ready}, 2'b10);
    step();
    chk("f_ready", {if_ready, mem_ready, stall_if}, 3'b100);
    chk("f_rdata", if_rdata, 32'hDEADBEEF);
    if_req = 1'b0;
    step();
    chk("f_t5", if_ready, 0);
    // store
    mem_we = 1'b1; mem_addr = 32'h100; mem_wdata = 32'h12345678;
    step();
    chk("s_t1", {ram_en, ram_we, ram_addr, ram_wdata}, {2'b11, 32'h100, 32'h12345678});
    step();
    chk("s_ready", {mem_ready, if_ready, stall_mem}, 3'b100);
    chk("s_rdata", mem_rdata, 0);
    mem_we = 1'b0;
    step();
    // simultaneous: MEM first, then IF
    if_req = 1'b1; if_addr = 32'h80; mem_re = 1'b1; mem_addr = 32'h200;
    step();
    chk("sim_t1", {ram_en, ram_addr}, {1'b1, 32'h200});
    step(3);
    chk("sim_mready", {mem_ready, if_ready, stall_if}, 3'b101);
    chk("sim_mrdata", mem_rdata, 32'h0200C0DE);
    mem_re = 1'b0;
    step(2);
    chk("sim_if_en", {ram_en, ram_addr}, {1'b1, 32'h80});
    step(3);
    chk("sim_iready", if_ready, 1);
    chk("sim_irdata", if_rdata, 32'h0080C0DE);
    if_req = 1'b0;
    step();
    // starvation: both held continuously
    if_req = 1'b1; if_addr = 32'h88; mem_re = 1'b1; mem_addr = 32'h204;
    seq = '0; n = 0; both = 0;
    for (int c = 0; c < 80 && n < 6; c++) begin
      step();
      if (mem_ready && if_ready) both++;
      if (ram_en) begin
        seq[n] = ram_addr == 32'h88;
        n++;
      end
    end
    chk("starve_n", n, 6);
    chk("starve_seq", seq, 6'b010000);
    chk("starve_both_rdy", both, 0);
    if_req = 1'b0; mem_re = 1'b0;
    step(6);
    exp_mrd = 32'h0204C0DE;
    chk("starve_mrdata", mem_rdata, exp_mrd);
    // mem_re and mem_we together act as a store
    mem_re = 1'b1; mem_we = 1'b1; mem_addr = 32'h300; mem_wdata = 32'hCAFEF00D;
    step();
    chk("rw_t1", {ram_en, ram_we, ram_wdata}, {2'b11, 32'hCAFEF00D});
    step();
    chk("rw_ready", mem_ready, 1);
    chk("rw_rdata", mem_rdata, exp_mrd);
    mem_re = 1'b0; mem_we = 1'b0;
    step();
    // reset in the middle of WAIT with the load still requested
    mem_re = 1'b1; mem_addr = 32'h500;
    step(2);
    rst = 1'b0;
    #1 chk("mr_outs", {ram_en, ram_we, ram_addr, ram_wdata}, 0);
    chk("mr_rdata", {if_rdata, mem_rdata}, 0);
    chk("mr_ready", {if_ready, mem_ready}, 0);
    step();
    rst = 1'b1;
    step();
    chk("mr_reissue", {ram_en, ram_addr}, {1'b1, 32'h500});
    step(3);
    chk("mr_ready2", {mem_ready, mem_rdata}, {1'b1, 32'h0500C0DE});
    mem_re = 1'b0;
    step();
    // MEM_LAT=1 build: read ready at t+3
    l1_re = 1'b1; l1_addr = 32'h44;
    step();
    chk("l1_en", {l1_ram_en, l1_ram_addr}, {1'b1, 32'h44});
    step();
    chk("l1_t2", l1_mem_ready, 0);
    step();
    chk("l1_ready", {l1_mem_ready, l1_mem_rdata}, {1'b1, 32'h0044C0DE});
    l1_re = 1'b0;
    step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer/arbiter sharing the single-port unified memory between the IF stage (instruction fetch, read-only) and the MEM stage (data load/store). Grants one requester per transaction and drives the memory port with registered signals. Waits a fixed read latency, returns data with a one-cycle ready pulse, and raises stall flags so the pipeline holds while a request is pending. Sits between the IF/MEM stages and the memory macro; MEM-stage outputs toward WB are unchanged.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, memory read latency in cycles from ram_en to valid ram_rdata (≥1)
- STARVE_MAX, 4, consecutive MEM grants with IF waiting before IF is forced a grant (≥1)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  ADDR_W  fetch address, stable while if_req
- if_rdata  out  DATA_W  fetched word, valid with if_ready
- if_ready  out  1  one-cycle completion pulse
- mem_re / mem_we  in  1  load / store request, held until mem_ready
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  store data
- mem_rdata  out  DATA_W  load data, valid with mem_ready
- mem_ready  out  1  one-cycle completion pulse
- ram_en / ram_we  out  1  memory enable / write enable (registered)
- ram_addr  out  ADDR_W  memory address (registered)
- ram_wdata  out  DATA_W  memory write data (registered)
- ram_rdata  in  DATA_W  memory read data
- stall_if / stall_mem  out  1  pending-request stall flags

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: sample requests. MEM request (mem_re|mem_we) has priority over if_req, unless starve counter = STARVE_MAX and if_req high, then IF granted. Latch grant owner, addr, wdata, write flag; go ISSUE.
- mem_re and mem_we both high: treated as store; read ignored.
- ISSUE (1 cycle): ram_en=1, ram_we=write flag, ram_addr/ram_wdata = latched. Store → DONE. Load/fetch → WAIT, lat counter loaded with MEM_LAT-1.
- WAIT: decrement counter each cycle; at 0 capture ram_rdata into owner's rdata register, go DONE. MEM_LAT=1 → WAIT lasts exactly 1 cycle.
- DONE (1 cycle): owner's ready=1; IDLE next. Requester drops or changes its request in the cycle after ready; request still high in IDLE is a new transaction.
- Starve counter: increments on each MEM grant while if_req high, saturates at STARVE_MAX; clears on any IF grant or when if_req low in IDLE.
- stall_if = if_req & ~if_ready; stall_mem = (mem_re|mem_we) & ~mem_ready (combinational).
- rdata registers hold last value until next capture for that owner; stores never update mem_rdata.

## Timing
- Reset (rst=0, async): state IDLE; ram_en, ram_we, ram_addr, ram_wdata, if_rdata, mem_rdata, if_ready, mem_ready, starve counter all 0. Reset mid-transaction drops it; held request is re-arbitrated after rst rises.
- Load/fetch sampled in IDLE at cycle t: ram_en at t+1, ram_rdata sampled at t+1+MEM_LAT, ready at t+2+MEM_LAT, next IDLE sample at t+3+MEM_LAT. Default MEM_LAT=2 → 5 cycles per read.
- Store sampled at t: ram_en=ram_we=1 at t+1, mem_ready at t+2, next sample t+3.
- ram_en high exactly one cycle per transaction; never both readies high in same cycle.
- Simultaneous IF and MEM in IDLE: MEM served first, IF sampled in following IDLE.

## Test plan
- Reset: drive rst=0 mid-WAIT with mem_re=1 → all outputs 0 immediately; after rst=1 load re-issued, ram_en one cycle later.
- Single fetch, if_addr=0x40, ram returns 0xDEADBEEF after 2 cycles → ram_en at t+1, if_ready and if_rdata=0xDEADBEEF at t+4, stall_if high t..t+3.
- Store mem_addr=0x100, mem_wdata=0x12345678 → ram_en=ram_we=1, ram_addr=0x100 at t+1, mem_ready at t+2, mem_rdata unchanged.
- Simultaneous if_req and mem_re → MEM granted first (mem_ready at t+4), IF ram_en at t+6, if_ready at t+9.
- Starvation: if_req and mem requests held continuously, STARVE_MAX=4 → exactly 4 MEM transactions then one IF grant, counter cleared.
- mem_re=mem_we=1 → treated as store: ram_we=1, no mem_rdata update; MEM_LAT=1 build: read ready at t+3.
